// File: rtl/sipo_rx.sv
// Purpose : serial-in/parallel-out receive stage; assembles a DATA_W-bit word from mosi while ss is low.
// Latency : valid pulses one clk after the edge that samples the final frame bit (busy=0).
// Backpressure: busy=1 parks the word in HOLD; frames that start before it is delivered are dropped (overrun).
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   ss, mosi      - active-low slave select (frame boundary) and serial data
//   busy          - downstream cannot take a word this cycle
//   err_clr       - synchronous clear of the sticky error flags (a same-cycle error still sets)
//   data_out      - last delivered word, changes only together with valid
//   valid         - one-cycle pulse marking a new data_out
//   frame_err     - sticky: ss rose before the frame was complete
//   overrun       - sticky: a new frame began while a word was still undelivered
//   parity_err    - sticky: even-parity mismatch (constant 0 unless RX_PARITY_EN)
//
// Build option: define RX_PARITY_EN to append an even-parity bit to every frame
// (DATA_W+1 serial bits; a mismatching frame is dropped and flags parity_err).

module sipo_rx #(
    parameter int DATA_W    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              mosi,
    input  logic              busy,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    // Serial bits per frame, including the optional parity bit.
`ifdef RX_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);

    // cnt holds the number of bits already sampled in the current frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PUBLISH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sr;
    logic              seen_high;

    // Decoded per-cycle events.
    logic take_bit;
    logic shift_en;
    logic trunc_evt;
    logic ovr_evt;
    logic publish;
    logic par_ok;

    // ------------------------------------------------------------------
    // Parity accumulator: running XOR of every sampled bit of the frame.
    // With even parity the XOR over payload plus parity bit must be 0.
    // ------------------------------------------------------------------
`ifdef RX_PARITY_EN
    logic par_acc;
    logic par_fail_evt;
    logic parity_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (state_nxt == S_IDLE) begin
                par_acc <= 1'b0;
            end else if (take_bit) begin
                par_acc <= par_acc ^ mosi;
            end
            parity_err_q <= par_fail_evt | (parity_err_q & ~err_clr);
        end
    end

    assign par_ok       = ~par_acc;
    assign par_fail_evt = (state == S_PUBLISH) && !par_ok;
    assign parity_err   = parity_err_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!ss) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ss) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                // A bad-parity word is dropped at once and never parks in HOLD.
                if (!par_ok || !busy) begin
                    state_nxt = ss ? S_IDLE : S_DRAIN;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!busy) begin
                    state_nxt = ss ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ss) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: decoded outputs / events
    // ------------------------------------------------------------------
    always_comb begin
        take_bit  = ((state == S_IDLE) || (state == S_SHIFT)) && !ss;
        // Only payload bits enter the shift register; the parity bit does not.
        shift_en  = take_bit && (cnt < DATA_CNT);
        trunc_evt = (state == S_SHIFT) && ss;
        // Low ss after a high ss while parked means a fresh frame is being lost.
        ovr_evt   = (state == S_HOLD) && seen_high && !ss;
        publish   = ((state == S_PUBLISH) && !busy && par_ok) ||
                    ((state == S_HOLD) && !busy);
    end

    // ------------------------------------------------------------------
    // Datapath: counter, shift register, output word, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sr        <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            seen_high <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                data_out <= sr;
            end

            // Returning to IDLE discards any partial or already-delivered word.
            if (state_nxt == S_IDLE) begin
                cnt <= '0;
                sr  <= '0;
            end else if (take_bit) begin
                cnt <= cnt + CNT_W'(1);
                if (shift_en) begin
                    if (LSB_FIRST) begin
                        sr <= {mosi, sr[DATA_W-1:1]};
                    end else begin
                        sr <= {sr[DATA_W-2:0], mosi};
                    end
                end
            end

            // seen_high covers the PUBLISH->HOLD edge as well as HOLD itself.
            if (state_nxt != S_HOLD) begin
                seen_high <= 1'b0;
            end else if (ss) begin
                seen_high <= 1'b1;
            end

            frame_err <= trunc_evt | (frame_err & ~err_clr);
            overrun   <= ovr_evt   | (overrun   & ~err_clr);
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    localparam int DATA_W    = 16;
    localparam bit LSB_FIRST = 1'b1;
`ifdef RX_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ss;
    logic              mosi;
    logic              busy;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    int                checks   = 0;
    int                failures = 0;

    // Monitor state, filled from DUT outputs as cycles elapse.
    int                cyc     = 0;
    int                n_valid = 0;
    int                vld_cyc = 0;
    logic [DATA_W-1:0] vld_dat = '0;

    always #5 clk = ~clk;

    sipo_rx #(
        .DATA_W   (DATA_W),
        .LSB_FIRST(LSB_FIRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .mosi      (mosi),
        .busy      (busy),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    // Reference bit order: serial bit i that must land so data_out equals w.
    function automatic logic ser_bit(input logic [DATA_W-1:0] w, input int i);
        return LSB_FIRST ? w[i] : w[DATA_W-1-i];
    endfunction

    // One clock: apply inputs, let a rising edge pass, observe at the falling edge.
    task automatic drive(input logic s, input logic m, input logic b);
        ss   = s;
        mosi = m;
        busy = b;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            n_valid++;
            vld_dat = data_out;
            vld_cyc = cyc;
        end
    endtask

    task automatic send_payload(input logic [DATA_W-1:0] w, input int nbits, input logic b);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, ser_bit(w, i), b);
        end
    endtask

    // Full, well-formed frame (payload plus correct parity bit when enabled).
    task automatic send_frame(input logic [DATA_W-1:0] w, input logic b);
        send_payload(w, DATA_W, b);
`ifdef RX_PARITY_EN
        drive(1'b0, ^w, b);
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; ss = 1'b1; mosi = 1'b0; busy = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", data_out); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {frame_err, overrun, parity_err});
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_basic;
        int last;
        send_frame(16'hA5C3, 1'b0);
        last = cyc;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || vld_cyc != last + 1) begin
            failures++; $display("FAIL basic_valid got=%b at %0d want=1 at %0d", valid, vld_cyc, last + 1);
        end
        checks++;
        if (data_out !== 16'hA5C3) begin failures++; $display("FAIL basic_data got=%h want=a5c3", data_out); end
        checks++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            failures++; $display("FAIL basic_flags got=%b want=000", {frame_err, overrun, parity_err});
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (valid !== 1'b0 || data_out !== 16'hA5C3) begin
            failures++; $display("FAIL basic_hold got valid=%b data=%h want valid=0 data=a5c3", valid, data_out);
        end
    endtask

    task automatic test_frame_err;
        int n0;
        n0 = n_valid;
        send_payload(16'h5A5A, 7, 1'b0);
        err_clr = 1'b1;                 // clear coincides with the error: set must win
        drive(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b want=1", frame_err); end
        repeat (3) drive(1'b1, 1'($urandom), 1'b0);
        checks++;
        if (n_valid != n0 || data_out !== 16'hA5C3) begin
            failures++; $display("FAIL ferr_novalid got n=%0d data=%h want n=%0d data=a5c3", n_valid, data_out, n0);
        end
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clr got=%b want=0", frame_err); end
        send_frame(16'h1234, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h1234 || frame_err !== 1'b0) begin
            failures++; $display("FAIL ferr_next got valid=%b data=%h ferr=%b want 1/1234/0", valid, data_out, frame_err);
        end
    endtask

    task automatic test_busy_hold;
        int n0;
        n0 = n_valid;
        send_frame(16'h00FF, 1'b0);
        repeat (5) drive(1'b1, 1'($urandom), 1'b1);
        checks++;
        if (n_valid != n0 || data_out !== 16'h1234) begin
            failures++; $display("FAIL hold_wait got n=%0d data=%h want n=%0d data=1234", n_valid, data_out, n0);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h00FF) begin
            failures++; $display("FAIL hold_pub got valid=%b data=%h want 1/00ff", valid, data_out);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (n_valid != n0 + 1) begin failures++; $display("FAIL hold_once got=%0d want=%0d", n_valid - n0, 1); end
    endtask

    task automatic test_overrun;
        int n0;
        n0 = n_valid;
        send_frame(16'h0F0F, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b1);
        send_payload(16'hFFFF, DATA_W, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b1 || n_valid != n0) begin
            failures++; $display("FAIL ovr_set got ovr=%b n=%0d want 1/%0d", overrun, n_valid - n0, 0);
        end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h0F0F) begin
            failures++; $display("FAIL ovr_pub got valid=%b data=%h want 1/0f0f", valid, data_out);
        end
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (n_valid != n0 + 1 || data_out !== 16'h0F0F) begin
            failures++; $display("FAIL ovr_lost got n=%0d data=%h want 1/0f0f", n_valid - n0, data_out);
        end
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b want=0", overrun); end
    endtask

    task automatic test_long_ss;
        int n0, last;
        logic [DATA_W-1:0] w;
        n0 = n_valid;
        w  = DATA_W'($urandom);
        send_frame(w, 1'b0);
        last = cyc;
        repeat (20 - FRAME_W) drive(1'b0, 1'($urandom), 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (n_valid != n0 + 1) begin failures++; $display("FAIL long_count got=%0d want=1", n_valid - n0); end
        checks++;
        if (vld_dat !== w || vld_cyc != last + 1) begin
            failures++; $display("FAIL long_data got=%h at %0d want=%h at %0d", vld_dat, vld_cyc, w, last + 1);
        end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL long_noferr got=%b want=0", frame_err); end
    endtask

    task automatic test_reset_mid;
        int n0;
        send_payload(16'hFFFF, 3, 1'b0);
        drive(1'b1, 1'b0, 1'b0);        // leaves frame_err set so reset must clear it
        n0 = n_valid;
        send_payload(16'hBEEF, 8, 1'b0);
        rst = 1'b1;
        ss  = 1'b1;
        #1;
        checks++;
        if (data_out !== '0 || valid !== 1'b0 || {frame_err, overrun, parity_err} !== 3'b000) begin
            failures++; $display("FAIL rst_mid got data=%h valid=%b flags=%b want 0/0/000",
                                 data_out, valid, {frame_err, overrun, parity_err});
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) drive(1'b1, 1'($urandom), 1'b0);
        checks++;
        if (n_valid != n0 || data_out !== '0) begin
            failures++; $display("FAIL rst_after got n=%0d data=%h want 0/0", n_valid - n0, data_out);
        end
    endtask

    task automatic test_parity;
`ifdef RX_PARITY_EN
        int n0;
        send_payload(16'h0001, DATA_W, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h0001 || parity_err !== 1'b0) begin
            failures++; $display("FAIL par_good got valid=%b data=%h perr=%b want 1/0001/0", valid, data_out, parity_err);
        end
        n0 = n_valid;
        send_payload(16'h0001, DATA_W, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (parity_err !== 1'b1 || valid !== 1'b0) begin
            failures++; $display("FAIL par_bad got perr=%b valid=%b want 1/0", parity_err, valid);
        end
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (n_valid != n0 || data_out !== 16'h0001) begin
            failures++; $display("FAIL par_drop got n=%0d data=%h want 0/0001", n_valid - n0, data_out);
        end
        err_clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (parity_err !== 1'b0) begin failures++; $display("FAIL par_clr got=%b want=0", parity_err); end
`else
        send_frame(16'h0001, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h0001 || parity_err !== 1'b0) begin
            failures++; $display("FAIL par_off got valid=%b data=%h perr=%b want 1/0001/0", valid, data_out, parity_err);
        end
`endif
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            int n0, last, d, gap;
            logic [DATA_W-1:0] w;
            w   = DATA_W'($urandom);
            d   = $urandom_range(0, 4);
            gap = $urandom_range(1, 3);
            n0  = n_valid;
            send_frame(w, 1'($urandom));
            last = cyc;
            for (int j = 0; j < d; j++) drive(1'b1, 1'($urandom), 1'b1);
            drive(1'b1, 1'($urandom), 1'b0);
            for (int j = 0; j < gap; j++) drive(1'b1, 1'($urandom), 1'($urandom));
            checks++;
            if (n_valid != n0 + 1) begin failures++; $display("FAIL rnd_count k=%0d got=%0d want=1", k, n_valid - n0); end
            checks++;
            if (vld_dat !== w) begin failures++; $display("FAIL rnd_data k=%0d got=%h want=%h", k, vld_dat, w); end
            checks++;
            if (vld_cyc != last + 1 + d) begin
                failures++; $display("FAIL rnd_time k=%0d got=%0d want=%0d", k, vld_cyc, last + 1 + d);
            end
        end
        checks++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            failures++; $display("FAIL rnd_flags got=%b want=000", {frame_err, overrun, parity_err});
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_frame_err;
        test_busy_hold;
        test_overrun;
        test_long_ss;
        test_reset_mid;
        test_parity;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in/parallel-out receive stage of the SPI-style slave datapath.
- Samples `mosi` on `clk` while `ss` is low and assembles a DATA_W-bit operand word.
- Hands the word to the downstream compute unit with a valid/busy handshake. The compute unit's `result`/`ready` then feed the PISO transmit stage.
- Detects truncated frames and frames arriving while a word is still undelivered.

Parameters:
- DATA_W, 16, payload bits per frame; must be at least 2.
- LSB_FIRST, 1, 1 = first serial bit lands in bit 0 (matches transmit order); 0 = first bit lands in bit DATA_W-1.

Ports:
- clk  in  1  system clock; every rising edge with ss=0 samples one bit.
- rst  in  1  asynchronous, active-high reset.
- ss  in  1  slave select, active low; frame boundary.
- mosi  in  1  serial data in.
- busy  in  1  downstream cannot accept a word this cycle.
- err_clr  in  1  synchronous clear of sticky error flags.
- data_out  out  DATA_W  last delivered word; held until the next delivery.
- valid  out  1  one-cycle pulse: data_out is new this cycle.
- frame_err  out  1  sticky: ss rose mid-frame.
- overrun  out  1  sticky: a new frame started while a word was still undelivered.
- parity_err  out  1  sticky: parity mismatch (see Optional Feature).

Behaviour:
- Reset (asynchronous):
  - data_out=0, valid=0, frame_err=0, overrun=0, parity_err=0.
  - Shift register and counter = 0; state = IDLE.
- valid is registered and is 0 in every cycle not listed below.
- IDLE:
  - ss=0: sample mosi as bit 1 of frame, cnt=1, go to SHIFT.
  - ss=1: no action.
- SHIFT:
  - ss=0: sample mosi, cnt++. When the sampled bit is bit DATA_W, go to PUBLISH.
  - ss=1 (cnt between 1 and DATA_W-1): set frame_err, discard partial word, cnt=0, go to IDLE. A truncated frame never produces valid.
- PUBLISH, on the edge after the last bit:
  - busy=0: data_out<=assembled word, valid=1 for this one cycle. Go to DRAIN if ss=0, else IDLE.
  - busy=1: go to HOLD.
- Latency: valid asserts one clk after the edge sampling the final bit, when busy=0.
- HOLD: keep the assembled word and re-evaluate busy every cycle.
  - busy=0: publish exactly as in PUBLISH, then go to DRAIN if ss=0, else IDLE.
  - Track whether ss has gone high since HOLD was entered.
  - If ss is then seen low again before publish: set overrun and discard the new frame's bits. After publish, go to DRAIN.
- DRAIN:
  - Ignore mosi. Extra clocks with ss=0 beyond DATA_W bits are dropped silently.
  - ss=1: go to IDLE, cnt=0.
- Bit placement:
  - LSB_FIRST=1: shift right, new bit entering at MSB, so bit 1 of the frame ends in data_out[0].
  - LSB_FIRST=0: shift left, new bit entering at LSB.
- Errors:
  - Flags are sticky until err_clr=1 or rst.
  - If err_clr and a new error event occur in the same cycle, set wins.
- rst mid-frame or mid-HOLD: word discarded, no valid, state IDLE.
- data_out never changes except on a valid cycle.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - Frame is DATA_W+1 bits; the final bit is the even-parity bit over the payload.
  - The last-bit transition to PUBLISH happens after bit DATA_W+1.
  - On mismatch: set parity_err, no valid, data_out unchanged; go to DRAIN, or IDLE if ss=1.
  - ss rising after exactly DATA_W bits counts as frame_err.
- Not defined: frame is DATA_W bits; parity_err is tied to 0.

Test Plan:
1. DATA_W=16, LSB_FIRST=1, busy=0; shift 0xA5C3 LSB first over 16 clks with ss=0 → valid one cycle after bit 16, data_out=0xA5C3, no flags.
2. ss rises after 7 bits → frame_err=1, no valid, data_out keeps prior value. Then err_clr=1 → frame_err=0. A following full frame 0x1234 delivers normally.
3. Full frame 0x00FF with busy=1 for 5 cycles after the last bit → valid only on the first cycle busy=0, data_out=0x00FF.
4. busy held 1 after frame 0x0F0F; ss goes high then low with 16 more bits → overrun=1. After busy drops, only 0x0F0F is delivered; the second frame is lost.
5. ss held low for 20 clks → exactly one valid, with the first 16 bits. Also: rst asserted at bit 9 → all outputs 0, no valid.
6. RX_PARITY_EN defined: payload 0x0001 with parity bit 1 → valid, data_out=0x0001. Same payload with parity bit 0 → parity_err=1, no valid.
